// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the command path.
//   cmd_state_e : assembler FSM state encoding (also exported for debug)
//   CMD_WIDTH   : command word width, shared with every command decoder
//   BYTE_WIDTH  : width of one byte from the host link FIFO
package cmd_pkg;

  localparam int CMD_WIDTH  = 16;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    GAP     = 2'd2
  } cmd_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping.
//   Clk_In : clock, posedge
//   Rst_N  : asynchronous active-low reset, clears Count
//   Inc    : add one this cycle (ignored once saturated)
//   Clr    : synchronous clear, wins over Inc
//   Count  : current value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clk_In,
  input  logic             Rst_N,
  input  logic             Inc,
  input  logic             Clr,
  output logic [WIDTH-1:0] Count
);

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc && (Count != '1)) begin
      Count <= Count + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_word_assembler.sv
// cmd_word_assembler: packs a byte stream into 16-bit command words, high byte
// first, and strobes each new word for one cycle. A half-received word is
// dropped after TIMEOUT_CYCLES idle cycles so framing re-synchronises.
//   Clk_In, Rst_N      : clock (posedge) and asynchronous active-low reset
//   Byte_In/Byte_Valid : byte from the host link FIFO
//   Byte_Ready         : block can take a byte this cycle
//   Sync_Clr           : synchronous flush of a partial word
//   Cmd_Out/Cmd_En     : last assembled word and its 1-cycle "new" strobe
//   Timeout_Err        : 1-cycle strobe, partial word dropped
//   Cmd_Count          : issued words, wraps
//   Err_Count          : timeouts, saturates at 8'hFF
//   State_Dbg          : current FSM state
//
// Handshake: a byte transfers on a posedge where Byte_Valid && Byte_Ready.
// Byte_Ready depends only on the state register and Sync_Clr, never on
// Byte_Valid, so the source may wait for Byte_Ready before raising Byte_Valid.
module cmd_word_assembler
  import cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd50000,
  parameter logic [3:0]  GAP_CYCLES     = 4'd0,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                  Clk_In,
  input  logic                  Rst_N,
  input  logic [BYTE_WIDTH-1:0] Byte_In,
  input  logic                  Byte_Valid,
  output logic                  Byte_Ready,
  input  logic                  Sync_Clr,
  output logic [CMD_WIDTH-1:0]  Cmd_Out,
  output logic                  Cmd_En,
  output logic                  Timeout_Err,
  output logic [CNT_WIDTH-1:0]  Cmd_Count,
  output logic [7:0]            Err_Count,
  output cmd_state_e            State_Dbg
);

  cmd_state_e            state, next_state;
  logic [23:0]           timer, timer_nxt;
  logic [3:0]            gap_cnt, gap_nxt;
  logic [BYTE_WIDTH-1:0] hi_byte;
  logic                  accept;
  logic                  latch_hi;
  logic                  issue;
  logic                  tmo;

  assign Byte_Ready = ((state == IDLE) || (state == WAIT_LO)) && !Sync_Clr;
  assign accept     = Byte_Valid && Byte_Ready;
  assign State_Dbg  = state;

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      state   <= IDLE;
      timer   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= next_state;
      timer   <= timer_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    next_state = state;
    timer_nxt  = timer;
    gap_nxt    = gap_cnt;
    latch_hi   = 1'b0;
    issue      = 1'b0;
    tmo        = 1'b0;
    if (Sync_Clr) begin
      next_state = IDLE;
      timer_nxt  = '0;
      gap_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            latch_hi   = 1'b1;
            timer_nxt  = '0;
            next_state = WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A low byte arriving in the timeout cycle still completes the word.
          if (accept) begin
            issue      = 1'b1;
            timer_nxt  = '0;
            gap_nxt    = '0;
            next_state = (GAP_CYCLES != 4'd0) ? GAP : IDLE;
          end else if (timer == TIMEOUT_CYCLES - 24'd1) begin
            tmo        = 1'b1;
            timer_nxt  = '0;
            next_state = IDLE;
          end else begin
            timer_nxt = timer + 24'd1;
          end
        end
        GAP: begin
          // The Cmd_En cycle is the first of the GAP_CYCLES idle cycles.
          if (gap_cnt == GAP_CYCLES - 4'd1) begin
            gap_nxt    = '0;
            next_state = IDLE;
          end else begin
            gap_nxt = gap_cnt + 4'd1;
          end
        end
        default: begin
          next_state = IDLE;
          timer_nxt  = '0;
          gap_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      hi_byte     <= '0;
      Cmd_Out     <= '0;
      Cmd_En      <= 1'b0;
      Timeout_Err <= 1'b0;
      Cmd_Count   <= '0;
    end else begin
      Cmd_En      <= issue;
      Timeout_Err <= tmo;
      if (Sync_Clr) begin
        hi_byte <= '0;
      end else if (latch_hi) begin
        hi_byte <= Byte_In;
      end
      if (issue) begin
        Cmd_Out   <= {hi_byte, Byte_In};
        Cmd_Count <= Cmd_Count + 1'b1;
      end
    end
  end

  // Sync_Clr keeps the error count, so the clear input is unused here.
  sat_counter #(
    .WIDTH (8)
  ) u_err_cnt (
    .Clk_In (Clk_In),
    .Rst_N  (Rst_N),
    .Inc    (tmo),
    .Clr    (1'b0),
    .Count  (Err_Count)
  );

endmodule
